// File: rtl/oc8051_priv_gate_ctrl_pkg.sv
// Shared types and constants for the supervisor gate controller.
// Latency: n/a (definitions only); backpressure: n/a.
package oc8051_priv_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    localparam logic [1:0] FLT_NONE = 2'b00;
    localparam logic [1:0] FLT_OVF  = 2'b01;
    localparam logic [1:0] FLT_UNF  = 2'b10;
    localparam logic [1:0] FLT_SIM  = 2'b11;

    localparam int DEF_NUM_GATES  = 4;
    localparam int DEF_LIFO_DEPTH = 8;
    localparam int DEF_CD_W       = 8;

endpackage

// File: rtl/oc8051_priv_gate_ctrl_if.sv
// Commit-event, gate-table config and privilege-pulse signals of the gate controller.
// Latency: n/a (wiring only); backpressure: none, events are always accepted.
interface oc8051_priv_gate_ctrl_if #(
    parameter int NUM_GATES  = 4,
    parameter int LIFO_DEPTH = 8
);
    logic                           call_valid;
    logic [15:0]                    call_target;
    logic                           ret_valid;
    logic                           cfg_we;
    logic [$clog2(NUM_GATES)-1:0]   cfg_idx;
    logic [15:0]                    cfg_addr;
    logic                           cfg_lock;
    logic                           enter_su_mode;
    logic                           leave_su_mode;
    logic                           su_active;
    logic [$clog2(LIFO_DEPTH):0]    frame_depth;
    logic                           fault;
    logic [1:0]                     fault_code;

    modport master (
        output call_valid, call_target, ret_valid,
        output cfg_we, cfg_idx, cfg_addr, cfg_lock,
        input  enter_su_mode, leave_su_mode, su_active, frame_depth, fault, fault_code
    );

    modport slave (
        input  call_valid, call_target, ret_valid,
        input  cfg_we, cfg_idx, cfg_addr, cfg_lock,
        output enter_su_mode, leave_su_mode, su_active, frame_depth, fault, fault_code
    );
endinterface

// File: rtl/oc8051_priv_lifo.sv
// Stack of call-depth values marking where each open gate frame began.
// Latency: push/pop visible next cycle; no backpressure, caller guards full/empty.
module oc8051_priv_lifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [W-1:0]              push_dat,
    output logic [W-1:0]              top,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;

    assign wr_idx  = AW'(cnt_q);
    assign top_idx = AW'(cnt_q - CNT_W'(1));

    // Push wins over pop so the two can never act in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (push && !full) begin
            mem[wr_idx] <= push_dat;
            cnt_q       <= cnt_q + CNT_W'(1);
        end else if (pop && !empty) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign top   = mem[top_idx];
    assign count = cnt_q;
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/oc8051_priv_gate_ctrl.sv
// Raises/drops supervisor mode on calls into and returns out of registered gate addresses.
// Latency: 1 cycle from committed event to pulse/status; no backpressure, one event per cycle.
module oc8051_priv_gate_ctrl
    import oc8051_priv_pkg::*;
#(
    parameter int NUM_GATES  = DEF_NUM_GATES,
    parameter int LIFO_DEPTH = DEF_LIFO_DEPTH,
    parameter int CD_W       = DEF_CD_W
) (
    input  logic                    clk,
    input  logic                    rst,
    oc8051_priv_gate_ctrl_if.slave  bus
);
    localparam int DEP_W = $clog2(LIFO_DEPTH) + 1;

    state_t                 state_q, state_d;
    logic [1:0]             fault_code_q, fault_code_d;
    logic [CD_W-1:0]        call_depth, call_depth_d;
    logic [15:0]            gate_addr [NUM_GATES];
    logic [NUM_GATES-1:0]   gate_valid;
    logic                   locked;
    logic                   enter_q, enter_d;
    logic                   leave_q, leave_d;
    logic                   cfg_ok;
    logic                   hit;
    logic                   push, pop;
    logic [CD_W-1:0]        lifo_top;
    logic [DEP_W-1:0]       lifo_count;
    logic                   lifo_full, lifo_empty;

    // Hit uses the registered table, so a same-cycle cfg write is not seen yet.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_GATES; i++) begin
            if (gate_valid[i] && (gate_addr[i] == bus.call_target)) begin
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        call_depth_d = call_depth;
        push         = 1'b0;
        pop          = 1'b0;
        enter_d      = 1'b0;
        leave_d      = 1'b0;
        cfg_ok       = 1'b0;
        case (state_q)
            RUN: begin
                cfg_ok = 1'b1;
                if (bus.call_valid && bus.ret_valid) begin
                    state_d      = FAULT;
                    fault_code_d = FLT_SIM;
                end else if (bus.call_valid && ((hit && lifo_full) || (&call_depth))) begin
                    state_d      = FAULT;
                    fault_code_d = FLT_OVF;
                end else if (bus.ret_valid && (call_depth == '0)) begin
                    state_d      = FAULT;
                    fault_code_d = FLT_UNF;
                end else if (bus.call_valid) begin
                    push         = hit;
                    enter_d      = hit;
                    call_depth_d = call_depth + CD_W'(1);
                end else if (bus.ret_valid) begin
                    // Only the return that brings depth back to the frame's entry depth closes it.
                    pop          = !lifo_empty && ((call_depth - CD_W'(1)) == lifo_top);
                    leave_d      = pop;
                    call_depth_d = call_depth - CD_W'(1);
                end
            end
            FAULT: begin
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            fault_code_q <= FLT_NONE;
            call_depth   <= '0;
            enter_q      <= 1'b0;
            leave_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fault_code_q <= fault_code_d;
            call_depth   <= call_depth_d;
            enter_q      <= enter_d;
            leave_q      <= leave_d;
        end
    end

    // A write issued together with the lock still lands before the table freezes.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_valid <= '0;
            locked     <= 1'b0;
            for (int i = 0; i < NUM_GATES; i++) begin
                gate_addr[i] <= '0;
            end
        end else if (cfg_ok && !locked) begin
            if (bus.cfg_we) begin
                gate_addr[bus.cfg_idx]  <= bus.cfg_addr;
                gate_valid[bus.cfg_idx] <= 1'b1;
            end
            if (bus.cfg_lock) begin
                locked <= 1'b1;
            end
        end
    end

    oc8051_priv_lifo #(
        .DEPTH (LIFO_DEPTH),
        .W     (CD_W)
    ) u_lifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .push_dat (call_depth),
        .top      (lifo_top),
        .count    (lifo_count),
        .full     (lifo_full),
        .empty    (lifo_empty)
    );

    assign bus.enter_su_mode = enter_q;
    assign bus.leave_su_mode = leave_q;
    assign bus.frame_depth   = lifo_count;
    assign bus.su_active     = (lifo_count != '0) && (state_q == RUN);
    assign bus.fault         = (state_q == FAULT);
    assign bus.fault_code    = fault_code_q;

endmodule

// File: tb/tb_oc8051_priv_gate_ctrl.sv
// Directed and randomized checks of the gate controller against a queue-based reference model.
module tb_oc8051_priv_gate_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oc8051_priv_gate_ctrl_if #(.NUM_GATES(4), .LIFO_DEPTH(8)) bus ();

    oc8051_priv_gate_ctrl #(.NUM_GATES(4), .LIFO_DEPTH(8), .CD_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: table, lock, depth counter, open frames as a list of entry depths.
    bit [15:0] m_ga [4];
    bit        m_gv [4];
    bit        m_locked;
    int        m_depth;
    int        m_frames [$];
    bit        m_faulted;
    bit [1:0]  m_code;
    bit        m_enter;
    bit        m_leave;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".enter"},  16'(bus.enter_su_mode), 16'(m_enter));
        check({tag, ".leave"},  16'(bus.leave_su_mode), 16'(m_leave));
        check({tag, ".depth"},  16'(bus.frame_depth),   16'(m_frames.size()));
        check({tag, ".su"},     16'(bus.su_active),     16'((m_frames.size() != 0) && !m_faulted));
        check({tag, ".fault"},  16'(bus.fault),         16'(m_faulted));
        check({tag, ".code"},   16'(bus.fault_code),    16'(m_code));
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_ga[i] = '0;
            m_gv[i] = 1'b0;
        end
        m_locked  = 1'b0;
        m_depth   = 0;
        m_frames.delete();
        m_faulted = 1'b0;
        m_code    = 2'b00;
        m_enter   = 1'b0;
        m_leave   = 1'b0;
    endfunction

    function automatic void model_step(input bit c, input bit [15:0] t, input bit r,
                                       input bit we, input bit [1:0] idx, input bit [15:0] a,
                                       input bit lk);
        bit is_gate = 1'b0;
        m_enter = 1'b0;
        m_leave = 1'b0;
        if (m_faulted) return;
        for (int i = 0; i < 4; i++) if (m_gv[i] && m_ga[i] == t) is_gate = 1'b1;
        if (c && r) begin
            m_faulted = 1'b1; m_code = 2'b11;
        end else if (c && (m_depth == 255 || (is_gate && m_frames.size() == 8))) begin
            m_faulted = 1'b1; m_code = 2'b01;
        end else if (r && m_depth == 0) begin
            m_faulted = 1'b1; m_code = 2'b10;
        end else if (c) begin
            if (is_gate) begin
                m_frames.push_back(m_depth);
                m_enter = 1'b1;
            end
            m_depth++;
        end else if (r) begin
            if (m_frames.size() > 0 && m_frames[$] == m_depth - 1) begin
                void'(m_frames.pop_back());
                m_leave = 1'b1;
            end
            m_depth--;
        end
        if (!m_locked) begin
            if (we) begin
                m_ga[idx] = a;
                m_gv[idx] = 1'b1;
            end
            if (lk) m_locked = 1'b1;
        end
    endfunction

    task automatic step(input string tag, input bit c, input bit [15:0] t, input bit r,
                        input bit we, input bit [1:0] idx, input bit [15:0] a, input bit lk);
        bus.call_valid  = c;
        bus.call_target = t;
        bus.ret_valid   = r;
        bus.cfg_we      = we;
        bus.cfg_idx     = idx;
        bus.cfg_addr    = a;
        bus.cfg_lock    = lk;
        model_step(c, t, r, we, idx, a, lk);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic call(input string tag, input bit [15:0] t);
        step(tag, 1'b1, t, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
    endtask

    task automatic ret(input string tag);
        step(tag, 1'b0, 16'h0, 1'b1, 1'b0, 2'd0, 16'h0, 1'b0);
    endtask

    task automatic cfg(input string tag, input bit [1:0] idx, input bit [15:0] a, input bit lk);
        step(tag, 1'b0, 16'h0, 1'b0, 1'b1, idx, a, lk);
    endtask

    task automatic do_reset(input string tag);
        bus.call_valid = 1'b0; bus.ret_valid = 1'b0; bus.cfg_we = 1'b0; bus.cfg_lock = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_all(tag);
    endtask

    initial begin
        bus.call_valid = 1'b0; bus.call_target = '0; bus.ret_valid = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_addr = '0; bus.cfg_lock = 1'b0;
        model_reset();

        // Program and hit, with a nested ordinary call.
        do_reset("rst0");
        cfg("prog", 2'd0, 16'h0100, 1'b1);
        call("hit", 16'h0100);
        call("plain", 16'h2000);
        ret("plain_ret");
        ret("gate_ret");

        // Writes after lock are dropped.
        cfg("locked_wr", 2'd1, 16'h0200, 1'b0);
        call("locked_call", 16'h0200);

        // Same-cycle write and call: call sees the old (empty) slot.
        do_reset("rst1");
        step("wr_and_call", 1'b1, 16'h0300, 1'b0, 1'b1, 2'd2, 16'h0300, 1'b0);
        call("new_entry", 16'h0300);

        // Nesting to full, then overflow.
        do_reset("rst2");
        cfg("prog2", 2'd0, 16'h0100, 1'b1);
        for (int i = 0; i < 8; i++) call("nest", 16'h0100);
        call("ovf", 16'h0100);
        ret("ret_in_fault");

        // Underflow, then gate call is ignored.
        do_reset("rst3");
        cfg("prog3", 2'd3, 16'h0100, 1'b0);
        ret("unf");
        call("call_in_fault", 16'h0100);

        // Simultaneous call/ret.
        do_reset("rst4");
        step("sim", 1'b1, 16'h1234, 1'b1, 1'b0, 2'd0, 16'h0, 1'b0);

        // Reset inside two frames clears table and lock.
        do_reset("rst5");
        cfg("prog5", 2'd0, 16'h0100, 1'b1);
        call("f1", 16'h0100);
        call("f2", 16'h0100);
        do_reset("rst_mid");
        call("stale_gate", 16'h0100);
        cfg("relock_wr", 2'd1, 16'h0400, 1'b0);
        call("after_rst_wr", 16'h0400);

        // Call-depth counter saturation.
        do_reset("rst6");
        for (int i = 0; i < 255; i++) call("deep", 16'h5555);
        call("cd_ovf", 16'h5555);

        // Randomized rounds.
        for (int round = 0; round < 20; round++) begin
            bit [15:0] pool [4];
            do_reset("rnd_rst");
            for (int i = 0; i < 4; i++) pool[i] = 16'($urandom_range(0, 15)) << 4;
            for (int n = 0; n < 150; n++) begin
                int  rr = $urandom_range(0, 99);
                bit  c = 1'b0, r = 1'b0, we, lk;
                bit [15:0] t;
                t  = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 3)]
                                                 : 16'($urandom_range(0, 255)) << 4;
                we = ($urandom_range(0, 9) == 0);
                lk = ($urandom_range(0, 39) == 0);
                if (rr < 2)       begin c = 1'b1; r = 1'b1; end
                else if (rr < 52) c = 1'b1;
                else if (rr < 88) r = 1'b1;
                if (r && !c && m_depth == 0 && $urandom_range(0, 9) != 0) r = 1'b0;
                step("rnd", c, t, r, we, 2'($urandom_range(0, 3)), pool[$urandom_range(0, 3)], lk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
